serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- It is the inverse operation of the team's 4-bit ripple-carry adder; where the adder propagates carry, this block propagates borrow.
- It uses a single full-subtractor cell plus shift registers, controlled by a start/busy/done handshake.
- It serves as the ALU's multi-cycle subtract path and as a cross-check against the combinational adder in lab benches.

---
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
// one full-subtractor step per clock, start/busy/done handshake.
// All outputs come straight from registers.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Full-subtractor borrow-out.
    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic             r_br;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_d;
    logic             w_br_next;
    logic             w_accept;
    logic             w_last;

    assign w_d       = fs_diff(r_a_sh[0], r_b_sh[0], r_br);
    assign w_br_next = fs_borrow(r_a_sh[0], r_b_sh[0], r_br);
    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST_CNT);

    // Next-state logic: accept in IDLE, count WIDTH bits in RUN, one cycle of DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_RUN);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    // Serial datapath: load operands on accept, shift one bit per RUN cycle,
    // publish the result only on the final bit so outputs never show partial bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_sh  <= {WIDTH{1'b0}};
            r_b_sh  <= {WIDTH{1'b0}};
            r_d_sh  <= {WIDTH{1'b0}};
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            r_diff  <= {WIDTH{1'b0}};
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_br    <= bin;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_cnt   <= {CW{1'b0}};
        end else if (r_state == S_RUN) begin
            r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_d_sh <= {w_d, r_d_sh[WIDTH-1:1]};
            r_br   <= w_br_next;
            r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (w_last) begin
                r_diff <= {w_d, r_d_sh[WIDTH-1:1]};
                r_bout <= w_br_next;
                r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            end else begin
                r_diff <= r_diff;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): an arithmetic
// reference model checked every cycle, plus literal expectations.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout, ovf;
    logic [W-1:0] diff;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_sub(input int ca, input int cb, input int cbin);
        int rd, sa, sb, sd;
        logic rb, ro;
        rd = (ca - cb - cbin) & ((1 << W) - 1);
        rb = (ca < cb + cbin);
        sa = (ca >= (1 << (W-1))) ? ca - (1 << W) : ca;
        sb = (cb >= (1 << (W-1))) ? cb - (1 << W) : cb;
        sd = sa - sb - cbin;
        ro = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
        return {ro, rb, rd[W-1:0]};
    endfunction

    // Behavioural model: timing from a remaining-bits counter, result from ref_sub.
    logic [W+1:0] m_res;
    int           m_left;
    bit           m_in_done;
    logic         e_busy, e_done, e_bout, e_ovf;
    logic [W-1:0] e_diff;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0; m_in_done <= 0; m_res <= '0;
            e_busy <= 0; e_done <= 0; e_diff <= '0; e_bout <= 0; e_ovf <= 0;
        end else if (m_in_done) begin
            e_done <= 0;
            m_in_done <= 0;
        end else if (m_left == 0) begin
            if (start) begin
                m_res  <= ref_sub(int'(a), int'(b), int'(bin));
                m_left <= W;
                e_busy <= 1;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                e_busy <= 0;
                e_done <= 1;
                m_in_done <= 1;
                {e_ovf, e_bout, e_diff} <= m_res;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_busy", busy, e_busy);
            chk("cyc_done", done, e_done);
            chk("cyc_diff", diff, e_diff);
            chk("cyc_bout", bout, e_bout);
            chk("cyc_ovf",  ovf,  e_ovf);
        end
    end

    // One directed operation with literal expectations and latency check.
    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini,
                         input logic [W-1:0] ed, input logic eb, input logic eo, input string nm);
        int n, nb;
        @(negedge clk);
        a = ai; b = bi; bin = bini; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        n = 0; nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, W);
        chk({nm, "_busycycles"}, nb, W);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_bout"}, bout, eb);
        chk({nm, "_ovf"}, ovf, eo);
        chk({nm, "_model"}, {e_ovf, e_bout, e_diff}, {eo, eb, ed});
        @(negedge clk);
        chk({nm, "_donepulse"}, done, 1'b0);
    endtask

    initial begin
        int last_done, n, ndone;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_res", {ovf, bout, diff}, '0);
        reset = 1'b0;

        do_op(4'b1011, 4'b1000, 1'b0, 4'b0011, 1'b0, 1'b0, "d1");
        do_op(4'b1011, 4'b1000, 1'b1, 4'b0010, 1'b0, 1'b0, "d2");
        do_op(4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0, "d3");
        do_op(4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1, "d4");
        do_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, "d5");
        do_op(4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, "d6");

        // start held high, operands scrambled every cycle: spacing W+2.
        @(negedge clk);
        start = 1'b1;
        last_done = -1;
        ndone = 0;
        n = 0;
        while (ndone < 4 && n < 100) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            @(negedge clk);
            n++;
            if (done) begin
                if (last_done >= 0) chk("b2b_spacing", cyc - last_done, W + 2);
                last_done = cyc;
                ndone++;
            end
        end
        chk("b2b_count", ndone, 4);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Async reset in the second RUN cycle.
        do_op(4'b1011, 4'b0001, 1'b0, 4'b1010, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        a = 4'b0110; b = 4'b0011; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_diff", diff, 4'b0000);
        chk("arst_bout", bout, 1'b0);
        chk("arst_ovf",  ovf,  1'b0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_nodone", ndone, 0);
        do_op(4'b0110, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0, "post_rst");

        // Randomized traffic, model checks every cycle.
        repeat (1500) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
